// File: rtl/secure_strobe_pkg.sv
// Shared types and helpers for the secure strobe transmitter: FSM states, default sync word,
// and the rolling tag function.
package secure_strobe_pkg;

  typedef enum logic [1:0] {StIdle, StSync, StData, StGap} state_e;

  localparam logic [5:0]  SyncWordDefault = 6'b001010;
  localparam int unsigned FifoDepth       = 4;
  localparam int unsigned NibbleW         = 4;

  function automatic logic [1:0] tag(input logic [1:0] seq, input logic [1:0] key);
    return seq ^ key;
  endfunction

endpackage

// File: rtl/strobe_fifo.sv
// Small synchronous FIFO holding payload nibbles; push is ignored when full, pop when empty.
module strobe_fifo
  import secure_strobe_pkg::*;
#(
  parameter int unsigned Depth = FifoDepth,
  parameter int unsigned Width = NibbleW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth < 2) ? 1 : $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/secure_strobe_tx.sv
// Secure strobe link transmitter: frames buffered nibbles as a sync word plus tagged data words.
// Optional mid-frame starvation abort is built when SECURE_STROBE_TIMEOUT_EN is defined.
module secure_strobe_tx
  import secure_strobe_pkg::*;
#(
  parameter logic [1:0]  KEY       = 2'b10,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned GAP       = 2,
  parameter logic [5:0]  SYNC_WORD = SyncWordDefault
`ifdef SECURE_STROBE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 8
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   in_data,
  output logic         in_ready,
  output logic [5:0]   d_out,
  output logic         strobe,
  output logic         busy
);

  localparam int unsigned GapW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  state_e          state_q;
  logic [3:0]      seq_q;
  logic [GapW-1:0] gap_q;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [3:0] fifo_rdata;
  logic       gap_expired, frame_done, stalling;

  strobe_fifo #(
    .Depth (FifoDepth),
    .Width (NibbleW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign busy        = (state_q != StIdle);
  // Counter is 1 in the last gap cycle and parks at 0 while stalled.
  assign gap_expired = (gap_q <= GapW'(1));
  assign frame_done  = (seq_q == 4'(FRAME_LEN));
  assign fifo_pop    = (state_q == StGap) && gap_expired && !frame_done && !fifo_empty;
  assign stalling    = (state_q == StGap) && gap_expired && !frame_done && fifo_empty;

`ifdef SECURE_STROBE_TIMEOUT_EN
  localparam int unsigned StarveW = $clog2(TIMEOUT + 1);

  logic [StarveW-1:0] starve_q;
  logic               starve_hit;

  assign starve_hit = stalling && (starve_q == StarveW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (fifo_pop || starve_hit) begin
      starve_q <= '0;
    end else if (stalling) begin
      starve_q <= starve_q + StarveW'(1);
    end
  end
`else
  logic starve_hit;
  assign starve_hit = 1'b0;
`endif

  // Outputs are registered on the edge entering SYNC/DATA so the strobe lines up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= '0;
      gap_q   <= '0;
      d_out   <= '0;
      strobe  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q <= StSync;
            d_out   <= SYNC_WORD;
            strobe  <= 1'b1;
            seq_q   <= '0;
          end
        end
        StSync, StData: begin
          state_q <= StGap;
          gap_q   <= GapW'(GAP);
        end
        StGap: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - GapW'(1);
          end
          if (gap_expired) begin
            if (frame_done) begin
              state_q <= StIdle;
            end else if (fifo_pop) begin
              state_q <= StData;
              d_out   <= {tag(seq_q[1:0], KEY), fifo_rdata};
              strobe  <= 1'b1;
              seq_q   <= seq_q + 4'd1;
            end else if (starve_hit) begin
              // Inverted tag guarantees the receiver rejects the partial frame.
              state_q <= StIdle;
              d_out   <= {~tag(seq_q[1:0], KEY), 4'h0};
              strobe  <= 1'b1;
              seq_q   <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_strobe_tx.sv
// Scoreboard bench for secure_strobe_tx: stimulus queues expected link words, a monitor checks strobes.
module tb_secure_strobe_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [5:0] d_out;
  logic       strobe;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_push_cyc = 0;
  int         idle_cyc = 0;
  int         last_stb = 0;
  logic       saw_full;
  logic [5:0] exp_q[$];
  int         stb_cyc[$];
  logic [5:0] mon_exp;

  secure_strobe_tx dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .d_out    (d_out),
    .strobe   (strobe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the next queued word.
  always @(negedge clk) begin
    if (!rst && strobe) begin
      vectors++;
      stb_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: d_out=%b with no word expected (cycle %0d)", d_out, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (d_out !== mon_exp) begin
          miscompares++;
          $display("FAIL link_word: d_out=%b, expected %b (cycle %0d)", d_out, mon_exp, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Holds in_valid until the nibble is accepted; records the push edge.
  task automatic push(input logic [3:0] nib);
    int n;
    in_valid = 1'b1;
    in_data  = nib;
    n = 0;
    while (!in_ready && n < 200) begin
      saw_full = 1'b1;
      tick();
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      tick();
      last_push_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    idle_cyc = cyc;
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    saw_full = 1'b0;
    tick();
    tick();
    check("reset_d_out", 32'(d_out), 32'd0);
    check("reset_strobe", 32'(strobe), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Nominal frame A,B,C,D.
    stb_cyc.delete();
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b101010);
    exp_q.push_back(6'b111011);
    exp_q.push_back(6'b001100);
    exp_q.push_back(6'b011101);
    push(4'hA);
    last_stb = last_push_cyc;
    push(4'hB);
    push(4'hC);
    push(4'hD);
    drain("nominal");
    if (stb_cyc.size() == 5) begin
      check("nominal_sync_latency", 32'(stb_cyc[0] - last_stb), 32'd1);
      for (int i = 1; i < 5; i++) begin
        check("nominal_strobe_period", 32'(stb_cyc[i] - stb_cyc[i-1]), 32'd3);
      end
      last_stb = stb_cyc[4];
    end else begin
      check("nominal_strobe_count", 32'(stb_cyc.size()), 32'd5);
    end
    wait_idle("nominal");
    check("nominal_idle_latency", 32'(idle_cyc - last_stb), 32'd3);

    // Backpressure: nibbles 1..8 across two frames.
    saw_full = 1'b0;
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b100001);
    exp_q.push_back(6'b110010);
    exp_q.push_back(6'b000011);
    exp_q.push_back(6'b010100);
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b100101);
    exp_q.push_back(6'b110110);
    exp_q.push_back(6'b000111);
    exp_q.push_back(6'b011000);
    for (int i = 1; i <= 8; i++) begin
      push(4'(i));
    end
    check("bp_in_ready_dropped", 32'(saw_full), 32'd1);
    drain("bp");
    wait_idle("bp");

`ifndef SECURE_STROBE_TIMEOUT_EN
    // Stall mid-frame after B, then resume with C and D.
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b101010);
    exp_q.push_back(6'b111011);
    push(4'hA);
    push(4'hB);
    drain("stall");
    for (int i = 0; i < 20; i++) tick();
    check("stall_strobe", 32'(strobe), 32'd0);
    check("stall_d_out_hold", 32'(d_out), 32'b111011);
    check("stall_busy", 32'(busy), 32'd1);
    stb_cyc.delete();
    exp_q.push_back(6'b001100);
    push(4'hC);
    last_stb = last_push_cyc;
    exp_q.push_back(6'b011101);
    push(4'hD);
    drain("stall_resume");
    if (stb_cyc.size() >= 1) begin
      check("stall_resume_latency", 32'(stb_cyc[0] - last_stb), 32'd1);
    end else begin
      check("stall_resume_count", 32'(stb_cyc.size()), 32'd2);
    end
    wait_idle("stall");
`else
    // Starvation abort after a single data word.
    stb_cyc.delete();
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b101010);
    exp_q.push_back(6'b000000);
    push(4'hA);
    drain("timeout");
    if (stb_cyc.size() == 3) begin
      check("timeout_abort_delay", 32'(stb_cyc[2] - stb_cyc[1]), 32'd10);
    end else begin
      check("timeout_strobe_count", 32'(stb_cyc.size()), 32'd3);
    end
    wait_idle("timeout");
`endif

    // Reset mid-frame after the second data strobe.
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b101010);
    exp_q.push_back(6'b111011);
    push(4'hA);
    push(4'hB);
    push(4'hC);
    push(4'hD);
    drain("midrst");
    tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_d_out", 32'(d_out), 32'd0);
    check("midrst_strobe", 32'(strobe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("midrst_quiet_busy", 32'(busy), 32'd0);
    check("midrst_quiet_d_out", 32'(d_out), 32'd0);
    exp_q.push_back(6'b001010);
    exp_q.push_back(6'b101110);
    exp_q.push_back(6'b111111);
    exp_q.push_back(6'b000001);
    exp_q.push_back(6'b010010);
    push(4'hE);
    push(4'hF);
    push(4'h1);
    push(4'h2);
    drain("restart");
    wait_idle("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
